// File: rtl/addsub_seq_pkg.sv
// Shared definitions for the sequential adder/subtractor controller.
// Holds the FSM state encoding and a small state decode helper.
package addsub_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The spare encoding 2'd3 behaves exactly like IDLE.
    function automatic logic is_idle(input state_t s);
        return (s != RUN) && (s != DONE);
    endfunction

endpackage

// File: rtl/addsub_seq_ctrl_if.sv
// Operand/result handshake bundle for addsub_seq_ctrl.
// The master side is the producer/consumer pair; the slave side is the controller.
interface addsub_seq_ctrl_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/addsub_seq_ctrl_rca_nbit.sv
// n-bit ripple-carry adder slice built from per-bit full adders.
// Purely combinational; the controller reuses it once per slice step.
module rca_nbit
    import addsub_seq_pkg::*;
#(
    parameter int n = 4
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         cin,
    output logic [n-1:0] s,
    output logic         cout
);
    logic [n:0] c;

    assign c[0] = cin;

    generate
        for (genvar gi = 0; gi < n; gi++) begin : g_fa
            assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
            assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = c[n];
endmodule

// File: rtl/addsub_seq_ctrl.sv
// Sequential W-bit add/subtract: one shared N-bit slice processes the operands
// LSB to MSB over K cycles, with the inter-slice carry held in a register.
module addsub_seq_ctrl
    import addsub_seq_pkg::*;
#(
    parameter int N = 4,
    parameter int K = 4
) (
    input  logic            clk,
    input  logic            rst,
    addsub_seq_ctrl_if.slave bus
);
    localparam int W     = N * K;
    localparam int IDX_W = $clog2(K);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(K - 1);

    state_t             state_reg;
    state_t             state_next;
    logic [IDX_W-1:0]   idx_reg;
    logic               carry_reg;
    logic [W-1:0]       a_reg;
    logic [W-1:0]       b_reg;
    logic [W-1:0]       sum_reg;
    logic               cout_reg;
    logic               ovf_reg;

    logic               accept;
    logic               step;
    logic               last;
    logic [N-1:0]       a_sl [K];
    logic [N-1:0]       b_sl [K];
    logic [N-1:0]       slice_a;
    logic [N-1:0]       slice_b;
    logic [N-1:0]       slice_s;
    logic               slice_co;

    generate
        for (genvar gi = 0; gi < K; gi++) begin : g_slice
            assign a_sl[gi] = a_reg[gi*N +: N];
            assign b_sl[gi] = b_reg[gi*N +: N];
        end
    endgenerate

    assign slice_a = a_sl[idx_reg];
    assign slice_b = b_sl[idx_reg];

    rca_nbit #(.n(N)) u_rca (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_reg),
        .s    (slice_s),
        .cout (slice_co)
    );

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        case (state_reg)
            RUN: begin
                step = 1'b1;
                last = (idx_reg == IDX_LAST);
                if (last) state_next = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_next = IDLE;
            end
            default: begin
                accept = bus.in_valid;
                if (bus.in_valid) state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Subtraction is folded into the operand load: invert B, seed carry with 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg   <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (accept) begin
            a_reg     <= bus.a;
            b_reg     <= bus.b ^ {W{bus.sub}};
            carry_reg <= bus.sub;
            idx_reg   <= '0;
        end else if (step) begin
            for (int i = 0; i < K; i++) begin
                if (idx_reg == IDX_W'(i)) sum_reg[i*N +: N] <= slice_s;
            end
            carry_reg <= slice_co;
            if (last) begin
                cout_reg <= slice_co;
                ovf_reg  <= (a_reg[W-1] == b_reg[W-1]) && (slice_s[N-1] != a_reg[W-1]);
            end else begin
                idx_reg <= idx_reg + IDX_W'(1);
            end
        end
    end

    assign bus.in_ready  = !rst && is_idle(state_reg);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.sum       = sum_reg;
    assign bus.cout      = cout_reg;
    assign bus.ovf       = ovf_reg;
endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Scoreboard bench for addsub_seq_ctrl: directed corner cases plus random
// operations, checked against an integer-arithmetic reference model.
module tb_addsub_seq_ctrl;
    localparam int N = 4;
    localparam int K = 4;
    localparam int W = N * K;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    addsub_seq_ctrl_if #(.W(W)) bus ();

    addsub_seq_ctrl #(.N(N), .K(K)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    res_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_txn = 0;

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        longint ua, ub, sa, sb, r, sr;
        res_t   e;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (s) begin
            r      = ua - ub;
            sr     = sa - sb;
            e.cout = (ua >= ub);
        end else begin
            r      = ua + ub;
            sr     = sa + sb;
            e.cout = (r >= (longint'(1) << W));
        end
        e.sum = r[W-1:0];
        e.ovf = (sr > ((longint'(1) << (W - 1)) - 1)) || (sr < -(longint'(1) << (W - 1)));
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        res_t e;
        if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_result: got sum=%h cout=%b ovf=%b required no result",
                         bus.sum, bus.cout, bus.ovf);
            end else begin
                e = exp_q.pop_front();
                n_txn++;
                if ({bus.sum, bus.cout, bus.ovf} !== e) begin
                    n_err++;
                    $display("FAIL result txn %0d: got sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                             n_txn, bus.sum, bus.cout, bus.ovf, e.sum, e.cout, e.ovf);
                end else begin
                    $display("txn %0d: sum=%h cout=%b ovf=%b ok", n_txn, bus.sum, bus.cout, bus.ovf);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            n_vec++;
            n_err++;
            $display("FAIL in_ready_timeout: got in_ready=%b required 1", bus.in_ready);
        end
    endtask

    // Issues one operation and checks out_valid appears exactly K edges later.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        wait_ready();
        bus.a        = a;
        bus.b        = b;
        bus.sub      = s;
        bus.in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(model(a, b, s));
        #1 bus.in_valid = 1'b0;
        for (int i = 1; i <= K; i++) begin
            tick();
            check("latency", 32'(bus.out_valid), 32'(i == K));
        end
    endtask

    initial begin
        logic [W-1:0] hold_sum;
        logic         hold_cout;
        int           n;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("in_ready_in_reset", 32'(bus.in_ready), 32'(0));
        rst = 1'b0;
        #1;
        check("reset_in_ready", 32'(bus.in_ready), 32'(1));
        check("reset_out_valid", 32'(bus.out_valid), 32'(0));
        check("reset_sum", 32'(bus.sum), 32'(0));
        check("reset_cout", 32'(bus.cout), 32'(0));
        check("reset_ovf", 32'(bus.ovf), 32'(0));

        do_op(16'h1234, 16'h0FCD, 1'b0);
        do_op(16'hFFFF, 16'h0001, 1'b0);
        do_op(16'h0005, 16'h0007, 1'b1);
        do_op(16'h0007, 16'h0005, 1'b1);
        do_op(16'h7FFF, 16'h0001, 1'b0);
        do_op(16'h8000, 16'h0001, 1'b1);
        tick();

        // Backpressure: DONE must hold while new operands are offered.
        bus.out_ready = 1'b0;
        do_op(16'h1357, 16'h2468, 1'b0);
        hold_sum  = bus.sum;
        hold_cout = bus.cout;
        for (int i = 0; i < 5; i++) begin
            bus.a        = 16'($urandom);
            bus.b        = 16'($urandom);
            bus.sub      = 1'($urandom);
            bus.in_valid = 1'b1;
            tick();
            check("bp_out_valid", 32'(bus.out_valid), 32'(1));
            check("bp_sum_stable", 32'(bus.sum), 32'(hold_sum));
            check("bp_cout_stable", 32'(bus.cout), 32'(hold_cout));
            check("bp_in_ready", 32'(bus.in_ready), 32'(0));
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        check("bp_release_in_ready", 32'(bus.in_ready), 32'(1));
        check("bp_release_out_valid", 32'(bus.out_valid), 32'(0));
        tick();
        check("same_edge_not_taken", 32'(bus.in_ready), 32'(1));

        // Reset in the middle of RUN with idx=2.
        wait_ready();
        bus.a        = 16'h1234;
        bus.b        = 16'h1111;
        bus.sub      = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("midrun_rst_in_ready", 32'(bus.in_ready), 32'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("midrun_in_ready", 32'(bus.in_ready), 32'(1));
        check("midrun_out_valid", 32'(bus.out_valid), 32'(0));
        check("midrun_sum", 32'(bus.sum), 32'(0));
        check("midrun_cout", 32'(bus.cout), 32'(0));
        check("midrun_ovf", 32'(bus.ovf), 32'(0));
        do_op(16'h0001, 16'h0001, 1'b0);
        tick();

        for (int t = 0; t < 30; t++) begin
            logic [W-1:0] ra, rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (t % 7 == 0) ra = 16'h8000;
            if (t % 5 == 0) rb = 16'hFFFF;
            bus.out_ready = 1'($urandom_range(0, 1));
            do_op(ra, rb, 1'($urandom));
            repeat ($urandom_range(0, 3)) tick();
            bus.out_ready = 1'b1;
            tick();
        end

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got %0d pending results required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
